gnr_attractor_ctrl: RTL and testbench



---
 rtl/gnr_attractor_ctrl.sv | 142 ++++++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gnr_attractor_ctrl.sv
// Floyd-cycle sequencer for a two-copy Boolean-network node array: load, tortoise/hare run, period walk.
// Node outputs are registered, so each cycle's compare sees the starts of the previous cycle; start is ignored while busy.
module gnr_attractor_ctrl #(
   parameter int N_NODES   = 16,
   parameter int CNT_W     = 32,
   parameter int MAX_STEPS = 65535
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_NODES-1:0] init_vec,
   input  logic [N_NODES-1:0] net_s0,
   input  logic [N_NODES-1:0] net_s1,
   output logic               reset_nos,
   output logic [N_NODES-1:0] init_state,
   output logic               start_s0,
   output logic               start_s1,
   output logic               busy,
   output logic               done,
   output logic               found,
   output logic               timeout,
   output logic [CNT_W-1:0]   meet_steps,
   output logic [CNT_W-1:0]   period,
   output logic [N_NODES-1:0] attractor_state
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, PERIOD, DONE} state_t;

   typedef struct packed {
      logic               found;
      logic               timeout;
      logic [CNT_W-1:0]   meet_steps;
      logic [CNT_W-1:0]   period;
      logic [N_NODES-1:0] attractor_state;
   } result_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   c, c_nxt;
   logic [CNT_W-1:0]   p, p_nxt;
   logic [N_NODES-1:0] init_cap, init_cap_nxt;
   result_t            res, res_nxt;
   logic               c_even, match, pmatch, run_limit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         c        <= '0;
         p        <= '0;
         init_cap <= '0;
         res      <= '0;
      end else begin
         state    <= state_nxt;
         c        <= c_nxt;
         p        <= p_nxt;
         init_cap <= init_cap_nxt;
         res      <= res_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      c_nxt        = c;
      p_nxt        = p;
      init_cap_nxt = init_cap;
      res_nxt      = res;
      reset_nos    = 1'b0;
      init_state   = '0;
      start_s0     = 1'b0;
      start_s1     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      c_even       = ~c[0];
      // At even c the tortoise has taken c/2 steps and the hare c steps.
      match        = (net_s0 == net_s1) && c_even && (c >= CNT_W'(2));
      run_limit    = c_even && ({1'b0, c[CNT_W-1:1]} == MAX_CNT);
      pmatch       = (net_s1 == net_s0) && (p >= CNT_W'(1));

      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               init_cap_nxt = init_vec;
               res_nxt      = '0;
               state_nxt    = LOAD;
            end
         end
         LOAD: begin
            busy       = 1'b1;
            reset_nos  = 1'b1;
            init_state = init_cap;
            c_nxt      = '0;
            state_nxt  = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (match) begin
               res_nxt.meet_steps      = c >> 1;
               res_nxt.attractor_state = net_s0;
               p_nxt                   = '0;
               state_nxt               = PERIOD;
            end else if (run_limit) begin
               res_nxt.timeout = 1'b1;
               state_nxt       = DONE;
            end else begin
               start_s0 = 1'b1;
               start_s1 = 1'b1;
               c_nxt    = sat_inc(c);
            end
         end
         PERIOD: begin
            // Tortoise stays parked on the cycle while the hare walks around it once.
            busy = 1'b1;
            if (pmatch) begin
               res_nxt.period = p;
               res_nxt.found  = 1'b1;
               state_nxt      = DONE;
            end else if (p == MAX_CNT) begin
               res_nxt.timeout = 1'b1;
               res_nxt.found   = 1'b0;
               state_nxt       = DONE;
            end else begin
               start_s1 = 1'b1;
               p_nxt    = sat_inc(p);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign found           = res.found;
   assign timeout         = res.timeout;
   assign meet_steps      = res.meet_steps;
   assign period          = res.period;
   assign attractor_state = res.attractor_state;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: two instances (default limit and MAX_STEPS=3) driving behavioural 4-node networks.
// Stimulus pushes expected results into per-instance queues; monitors pop and compare on each rising done.
module tb_gnr_attractor_ctrl;

   typedef struct packed {
      logic        found;
      logic        timeout;
      logic [31:0] meet;
      logic [31:0] per;
      logic [3:0]  st;
   } exp_t;

   logic        clk, rst;
   logic        start_a, start_b;
   logic [3:0]  init_a, init_b;
   logic        net_mode;

   logic [3:0]  s0_a, s1_a, s0_b, s1_b;
   logic        pass_a, pass_b;

   logic        reset_nos_a, start_s0_a, start_s1_a, busy_a, done_a, found_a, timeout_a;
   logic [3:0]  init_state_a, attr_a;
   logic [31:0] meet_a, period_a;
   logic        reset_nos_b, start_s0_b, start_s1_b, busy_b, done_b, found_b, timeout_b;
   logic [3:0]  init_state_b, attr_b;
   logic [31:0] meet_b, period_b;

   logic [127:0] outs_a, outs_b;
   logic [8:0]   trace_a;

   int   checks = 0;
   int   failures = 0;
   exp_t exp_a[$];
   exp_t exp_b[$];
   int   s1_cnt_a = 0, rn_cnt_a = 0, s1_cnt_b = 0;
   logic done_a_q = 1'b0, done_b_q = 1'b0;

   gnr_attractor_ctrl #(.N_NODES(4), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .init_vec(init_a),
      .net_s0(s0_a), .net_s1(s1_a),
      .reset_nos(reset_nos_a), .init_state(init_state_a),
      .start_s0(start_s0_a), .start_s1(start_s1_a),
      .busy(busy_a), .done(done_a), .found(found_a), .timeout(timeout_a),
      .meet_steps(meet_a), .period(period_a), .attractor_state(attr_a)
   );

   gnr_attractor_ctrl #(.N_NODES(4), .CNT_W(32), .MAX_STEPS(3)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .init_vec(init_b),
      .net_s0(s0_b), .net_s1(s1_b),
      .reset_nos(reset_nos_b), .init_state(init_state_b),
      .start_s0(start_s0_b), .start_s1(start_s1_b),
      .busy(busy_b), .done(done_b), .found(found_b), .timeout(timeout_b),
      .meet_steps(meet_b), .period(period_b), .attractor_state(attr_b)
   );

   assign outs_a = {49'd0, reset_nos_a, init_state_a, start_s0_a, start_s1_a, busy_a, done_a,
                    found_a, timeout_a, meet_a, period_a, attr_a};
   assign outs_b = {49'd0, reset_nos_b, init_state_b, start_s0_b, start_s1_b, busy_b, done_b,
                    found_b, timeout_b, meet_b, period_b, attr_b};
   assign trace_a = {reset_nos_a, start_s0_a, start_s1_a, busy_a, done_a, init_state_a};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Network update rule: identity (mode 0) or rotate-left ring (mode 1).
   function automatic logic [3:0] nf(input logic m, input logic [3:0] v);
      return m ? {v[2:0], v[3]} : v;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         s0_a <= '0; s1_a <= '0; pass_a <= 1'b0;
      end else if (reset_nos_a) begin
         s0_a <= init_state_a; s1_a <= init_state_a; pass_a <= 1'b1;
      end else begin
         if (start_s0_a) begin
            if (pass_a) s0_a <= nf(net_mode, s0_a);
            pass_a <= ~pass_a;
         end
         if (start_s1_a) s1_a <= nf(net_mode, s1_a);
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         s0_b <= '0; s1_b <= '0; pass_b <= 1'b0;
      end else if (reset_nos_b) begin
         s0_b <= init_state_b; s1_b <= init_state_b; pass_b <= 1'b1;
      end else begin
         if (start_s0_b) begin
            if (pass_b) s0_b <= nf(net_mode, s0_b);
            pass_b <= ~pass_b;
         end
         if (start_s1_b) s1_b <= nf(net_mode, s1_b);
      end
   end

   always @(negedge clk) begin
      if (start_s1_a)  s1_cnt_a = s1_cnt_a + 1;
      if (reset_nos_a) rn_cnt_a = rn_cnt_a + 1;
      if (start_s1_b)  s1_cnt_b = s1_cnt_b + 1;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks = checks + 1;
      if (act !== req) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic f, input logic t, input int m, input int pr, input logic [3:0] s);
      exp_t e;
      e.found = f; e.timeout = t; e.meet = 32'(m); e.per = 32'(pr); e.st = s;
      return e;
   endfunction

   task automatic sb_cmp(input string tag, input exp_t e, input logic f, input logic t,
                         input logic [31:0] m, input logic [31:0] pr, input logic [3:0] s);
      chk({tag, "_found"},      128'(f),  128'(e.found));
      chk({tag, "_timeout"},    128'(t),  128'(e.timeout));
      chk({tag, "_meet_steps"}, 128'(m),  128'(e.meet));
      chk({tag, "_period"},     128'(pr), 128'(e.per));
      chk({tag, "_attractor"},  128'(s),  128'(e.st));
   endtask

   always @(negedge clk) begin
      if (done_a && !done_a_q) begin
         chk("a_done_expected", 128'(exp_a.size() > 0), 128'(1));
         if (exp_a.size() > 0) sb_cmp("a", exp_a.pop_front(), found_a, timeout_a, meet_a, period_a, attr_a);
      end
      if (done_b && !done_b_q) begin
         chk("b_done_expected", 128'(exp_b.size() > 0), 128'(1));
         if (exp_b.size() > 0) sb_cmp("b", exp_b.pop_front(), found_b, timeout_b, meet_b, period_b, attr_b);
      end
      done_a_q = done_a;
      done_b_q = done_b;
   end

   task automatic run_a(input logic [3:0] v);
      @(posedge clk); #1 start_a = 1'b1; init_a = v;
      @(posedge clk); #1 start_a = 1'b0;
   endtask

   task automatic wait_done(input logic sel_b, input string name);
      for (int i = 0; i < 200 && !(sel_b ? done_b : done_a); i++) @(negedge clk);
      chk(name, 128'(sel_b ? done_b : done_a), 128'(1));
   endtask

   logic [8:0] id_trace [7];
   int s1_snap, rn_snap;

   initial begin
      id_trace = '{9'b1_0_0_1_0_1010, 9'b0_1_1_1_0_0000, 9'b0_1_1_1_0_0000, 9'b0_0_0_1_0_0000,
                   9'b0_0_1_1_0_0000, 9'b0_0_0_1_0_0000, 9'b0_0_0_0_1_0000};
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; init_a = '0; init_b = '0; net_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_outs_a", outs_a, 128'(0));
      chk("reset_outs_b", outs_b, 128'(0));

      // Identity network: cycle-exact control trace from LOAD to DONE.
      net_mode = 1'b0;
      exp_a.push_back(mk(1'b1, 1'b0, 1, 1, 4'b1010));
      run_a(4'b1010);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk($sformatf("id_trace%0d", i), 128'(trace_a), 128'(id_trace[i]));
      end

      // Rotate-left ring from 0001.
      net_mode = 1'b1;
      s1_snap = s1_cnt_a; rn_snap = rn_cnt_a;
      exp_a.push_back(mk(1'b1, 1'b0, 4, 4, 4'b0001));
      run_a(4'b0001);
      wait_done(1'b0, "ring_done");
      chk("ring_s1_pulses", 128'(s1_cnt_a - s1_snap), 128'(12));
      chk("ring_reset_nos", 128'(rn_cnt_a - rn_snap), 128'(1));

      // Same ring with a stray start during RUN carrying a different init.
      s1_snap = s1_cnt_a; rn_snap = rn_cnt_a;
      exp_a.push_back(mk(1'b1, 1'b0, 4, 4, 4'b0001));
      run_a(4'b0001);
      repeat (3) @(posedge clk);
      #1 start_a = 1'b1; init_a = 4'b1111;
      @(posedge clk); #1 start_a = 1'b0;
      wait_done(1'b0, "busy_start_done");
      chk("busy_start_s1_pulses", 128'(s1_cnt_a - s1_snap), 128'(12));
      chk("busy_start_reset_nos", 128'(rn_cnt_a - rn_snap), 128'(1));

      // Back-to-back from DONE with a period-2 init; results clear on accept.
      exp_a.push_back(mk(1'b1, 1'b0, 2, 2, 4'b0101));
      run_a(4'b0101);
      @(negedge clk);
      chk("b2b_cleared", 128'({found_a, timeout_a, period_a, meet_a, attr_a}), 128'(0));
      wait_done(1'b0, "b2b_done");

      // Abort in PERIOD: no done for this run, then a clean rerun.
      run_a(4'b0001);
      for (int i = 0; i < 200 && !(busy_a && start_s1_a && !start_s0_a); i++) @(negedge clk);
      chk("abort_in_period", 128'(busy_a && start_s1_a && !start_s0_a), 128'(1));
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_outs_a", outs_a, 128'(0));
      repeat (3) @(negedge clk);
      chk("abort_no_done", 128'(done_a), 128'(0));
      exp_a.push_back(mk(1'b1, 1'b0, 4, 4, 4'b0001));
      run_a(4'b0001);
      wait_done(1'b0, "rerun_done");

      // Limited instance times out at c=6 on the ring.
      s1_snap = s1_cnt_b;
      exp_b.push_back(mk(1'b0, 1'b1, 0, 0, 4'b0000));
      @(posedge clk); #1 start_b = 1'b1; init_b = 4'b0001;
      @(posedge clk); #1 start_b = 1'b0;
      wait_done(1'b1, "timeout_done");
      chk("timeout_s1_pulses", 128'(s1_cnt_b - s1_snap), 128'(6));
      repeat (2) @(negedge clk);
      chk("timeout_starts_low", 128'({start_s0_b, start_s1_b, busy_b, done_b}), 128'(4'b0001));

      repeat (3) @(negedge clk);
      chk("sb_a_drained", 128'(exp_a.size()), 128'(0));
      chk("sb_b_drained", 128'(exp_b.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
